s3g_tx_arbiter: RTL and testbench

//  Shares the single s3g_tx packet sender between two requesters:

---
 rtl/s3g_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_s3g_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_tx_arbiter.sv
// Two-port round-robin front end for the s3g_tx packet sender: each requester
// has a one-deep holding slot, and the shared output buffer is held until the sender is done.
module s3g_tx_arbiter #(
    parameter int MAX_LEN       = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_wr,
    input  logic [7:0]   req0_len,
    input  logic [127:0] req0_buf,
    output logic         req0_busy,
    output logic         req0_done,
    output logic         req0_err,
    input  logic         req1_wr,
    input  logic [7:0]   req1_len,
    input  logic [127:0] req1_buf,
    output logic         req1_busy,
    output logic         req1_done,
    output logic         req1_err,
    input  logic         tx_busy,
    output logic         tx_packet_wr,
    output logic [7:0]   tx_payload_len,
    output logic [127:0] tx_buf
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    state_t         state_reg;
    logic           rr_last_reg;
    logic           grant_reg;
    logic           grant_next;
    logic [TW-1:0]  timer_reg;
    logic           tx_packet_wr_reg;
    logic [7:0]     tx_len_reg;
    logic [127:0]   tx_buf_reg;
    logic           start_expired;
    logic           release_now;

    logic [1:0]     req_wr;
    logic [7:0]     req_len [2];
    logic [127:0]   req_buf [2];
    logic [1:0]     slot_valid;
    logic [1:0]     slot_done;
    logic [1:0]     slot_err;
    logic [7:0]     slot_len [2];
    logic [127:0]   slot_buf [2];

    assign req_wr     = {req1_wr, req0_wr};
    assign req_len[0] = req0_len;
    assign req_len[1] = req1_len;
    assign req_buf[0] = req0_buf;
    assign req_buf[1] = req1_buf;

    // A sender that never raises tx_busy is treated as having finished the packet.
    assign start_expired = (timer_reg == TW'(START_TIMEOUT - 1));
    assign release_now   = ((state_reg == ST_WAIT_DONE) && !tx_busy) ||
                           ((state_reg == ST_WAIT_START) && !tx_busy && start_expired);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic         valid_reg;
            logic         done_reg;
            logic         err_reg;
            logic [7:0]   len_reg;
            logic [127:0] data_reg;
            logic         oversize;
            logic         accept;
            logic         release_mine;

            assign oversize     = (req_len[gi] > 8'(MAX_LEN));
            assign accept       = req_wr[gi] && !valid_reg && !oversize;
            assign release_mine = release_now && (int'(grant_reg) == gi);

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    len_reg   <= '0;
                    data_reg  <= '0;
                end else begin
                    done_reg <= release_mine;
                    err_reg  <= req_wr[gi] && (valid_reg || oversize);
                    if (release_mine) begin
                        valid_reg <= 1'b0;
                    end else if (accept) begin
                        valid_reg <= 1'b1;
                        len_reg   <= req_len[gi];
                        data_reg  <= req_buf[gi];
                    end
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_done[gi]  = done_reg;
            assign slot_err[gi]   = err_reg;
            assign slot_len[gi]   = len_reg;
            assign slot_buf[gi]   = data_reg;
        end
    endgenerate

    // On a tie the port that was not served last goes next.
    always_comb begin
        grant_next = 1'b0;
        if (slot_valid[0] && slot_valid[1]) begin
            grant_next = ~rr_last_reg;
        end else begin
            grant_next = ~slot_valid[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            rr_last_reg      <= 1'b1;
            grant_reg        <= 1'b0;
            timer_reg        <= '0;
            tx_packet_wr_reg <= 1'b0;
            tx_len_reg       <= '0;
            tx_buf_reg       <= '0;
        end else begin
            tx_packet_wr_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if ((|slot_valid) && !tx_busy) begin
                        grant_reg        <= grant_next;
                        rr_last_reg      <= grant_next;
                        tx_len_reg       <= slot_len[grant_next];
                        tx_buf_reg       <= slot_buf[grant_next];
                        tx_packet_wr_reg <= 1'b1;
                        state_reg        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        state_reg <= ST_WAIT_DONE;
                    end else if (start_expired) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req0_busy      = slot_valid[0];
    assign req1_busy      = slot_valid[1];
    assign req0_done      = slot_done[0];
    assign req1_done      = slot_done[1];
    assign req0_err       = slot_err[0];
    assign req1_err       = slot_err[1];
    assign tx_packet_wr   = tx_packet_wr_reg;
    assign tx_payload_len = tx_len_reg;
    assign tx_buf         = tx_buf_reg;

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Directed bench for s3g_tx_arbiter: a small s3g_tx stand-in logs every packet and
// pulse by cycle number, and each test task compares the log with hand-computed values.
module tb_s3g_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_wr, req1_wr;
    logic [7:0]   req0_len, req1_len;
    logic [127:0] req0_buf, req1_buf;
    logic         req0_busy, req0_done, req0_err;
    logic         req1_busy, req1_done, req1_err;
    logic         tx_busy;
    logic         tx_packet_wr;
    logic [7:0]   tx_payload_len;
    logic [127:0] tx_buf;

    s3g_tx_arbiter #(.MAX_LEN(16), .START_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0_wr(req0_wr), .req0_len(req0_len), .req0_buf(req0_buf),
        .req0_busy(req0_busy), .req0_done(req0_done), .req0_err(req0_err),
        .req1_wr(req1_wr), .req1_len(req1_len), .req1_buf(req1_buf),
        .req1_busy(req1_busy), .req1_done(req1_done), .req1_err(req1_err),
        .tx_busy(tx_busy), .tx_packet_wr(tx_packet_wr),
        .tx_payload_len(tx_payload_len), .tx_buf(tx_buf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int           cyc;
    int           busy_left;
    int           pkt_cyc [$];
    int           pkt_len [$];
    logic [127:0] pkt_buf [$];
    int           done0_cyc [$];
    int           done1_cyc [$];
    int           err0_cyc [$];
    int           err1_cyc [$];
    int           hold_viol;
    int           busy0_seen;
    logic [7:0]   last_len;
    logic [127:0] last_buf;

    function automatic int pcyc(input int i);
        return (i < pkt_cyc.size()) ? pkt_cyc[i] : -1;
    endfunction
    function automatic int plen(input int i);
        return (i < pkt_len.size()) ? pkt_len[i] : -1;
    endfunction
    function automatic logic [127:0] pbuf(input int i);
        return (i < pkt_buf.size()) ? pkt_buf[i] : 'x;
    endfunction
    function automatic int d0(input int i);
        return (i < done0_cyc.size()) ? done0_cyc[i] : -1;
    endfunction
    function automatic int d1(input int i);
        return (i < done1_cyc.size()) ? done1_cyc[i] : -1;
    endfunction

    task automatic clear_log();
        cyc = 0;
        pkt_cyc.delete(); pkt_len.delete(); pkt_buf.delete();
        done0_cyc.delete(); done1_cyc.delete();
        err0_cyc.delete(); err1_cyc.delete();
        hold_viol  = 0;
        busy0_seen = 0;
        last_len   = tx_payload_len;
        last_buf   = tx_buf;
    endtask

    // Runs n cycles as the s3g_tx stand-in; busy_len=0 means tx_busy never rises.
    task automatic emulate(input int n, input int busy_len);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (tx_packet_wr) begin
                pkt_cyc.push_back(cyc);
                pkt_len.push_back(int'(tx_payload_len));
                pkt_buf.push_back(tx_buf);
                $display("tx packet: cyc=%0d len=%0d buf=%h", cyc, tx_payload_len, tx_buf);
            end else if (tx_payload_len !== last_len || tx_buf !== last_buf) begin
                hold_viol++;
            end
            last_len = tx_payload_len;
            last_buf = tx_buf;
            if (req0_done) done0_cyc.push_back(cyc);
            if (req1_done) done1_cyc.push_back(cyc);
            if (req0_err)  err0_cyc.push_back(cyc);
            if (req1_err)  err1_cyc.push_back(cyc);
            if (req0_busy) busy0_seen++;
            req0_wr = 1'b0;
            req1_wr = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            if (tx_packet_wr && busy_len > 0) begin
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end
        end
    endtask

    task automatic offer(input int port, input logic [7:0] len, input logic [127:0] data);
        if (port == 0) begin
            req0_wr = 1'b1; req0_len = len; req0_buf = data;
        end else begin
            req1_wr = 1'b1; req1_len = len; req1_buf = data;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req0_wr = 1'b0; req1_wr = 1'b0;
        tx_busy = 1'b0; busy_left = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (tx_packet_wr !== 1'b0) begin n_bad++; $display("FAIL reset_tx_wr: got %b, want 0", tx_packet_wr); end
        n_cmp++; if (tx_payload_len !== 8'd0) begin n_bad++; $display("FAIL reset_tx_len: got %0d, want 0", tx_payload_len); end
        n_cmp++; if (tx_buf !== 128'd0) begin n_bad++; $display("FAIL reset_tx_buf: got %h, want 0", tx_buf); end
        n_cmp++; if ({req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_req_flags: got %b, want 000000",
                              {req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_log();
        offer(0, 8'd3, 128'h030201);
        emulate(40, 30);
        n_cmp++; if (pkt_cyc.size() != 1) begin n_bad++; $display("FAIL single_pkt_count: got %0d, want 1", pkt_cyc.size()); end
        n_cmp++; if (pcyc(0) != 2) begin n_bad++; $display("FAIL single_latency: got cyc %0d, want 2", pcyc(0)); end
        n_cmp++; if (plen(0) != 3) begin n_bad++; $display("FAIL single_len: got %0d, want 3", plen(0)); end
        n_cmp++; if (pbuf(0) !== 128'h030201) begin n_bad++; $display("FAIL single_buf: got %h, want 030201", pbuf(0)); end
        n_cmp++; if (done0_cyc.size() != 1 || d0(0) != 33) begin
            n_bad++; $display("FAIL single_done: got %0d pulses first at %0d, want 1 at 33", done0_cyc.size(), d0(0));
        end
        n_cmp++; if (hold_viol != 0) begin n_bad++; $display("FAIL single_hold: got %0d changes, want 0", hold_viol); end
        n_cmp++; if (req0_busy !== 1'b0 || done1_cyc.size() != 0) begin
            n_bad++; $display("FAIL single_after: got busy0=%b done1=%0d, want 0 0", req0_busy, done1_cyc.size());
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        clear_log();
        offer(0, 8'd4, 128'h44);
        offer(1, 8'd5, 128'h55);
        emulate(20, 5);
        n_cmp++; if (plen(0) != 4 || plen(1) != 5) begin
            n_bad++; $display("FAIL simul_order_a: got lens %0d,%0d, want 4,5", plen(0), plen(1));
        end
        n_cmp++; if (pcyc(0) != 2 || pcyc(1) != 9) begin
            n_bad++; $display("FAIL simul_b2b_cyc: got %0d,%0d, want 2,9", pcyc(0), pcyc(1));
        end
        n_cmp++; if (d0(0) != 8 || d1(0) != 15) begin
            n_bad++; $display("FAIL simul_done_cyc: got %0d,%0d, want 8,15", d0(0), d1(0));
        end
        n_cmp++; if (pbuf(1) !== 128'h55 || hold_viol != 0) begin
            n_bad++; $display("FAIL simul_buf_hold: got %h viol=%0d, want 55 viol=0", pbuf(1), hold_viol);
        end
        // Single port-0 packet makes port 0 the last served, so the next tie goes to port 1.
        clear_log();
        offer(0, 8'd2, 128'h22);
        emulate(20, 5);
        n_cmp++; if (plen(0) != 2 || d0(0) != 8) begin
            n_bad++; $display("FAIL simul_single_mid: got len %0d done %0d, want 2 8", plen(0), d0(0));
        end
        clear_log();
        offer(0, 8'd6, 128'h66);
        offer(1, 8'd7, 128'h77);
        emulate(20, 5);
        n_cmp++; if (plen(0) != 7 || plen(1) != 6) begin
            n_bad++; $display("FAIL simul_order_b: got lens %0d,%0d, want 7,6", plen(0), plen(1));
        end
        n_cmp++; if (d1(0) != 8 || d0(0) != 15) begin
            n_bad++; $display("FAIL simul_done_b: got done1 %0d done0 %0d, want 8 15", d1(0), d0(0));
        end
    endtask

    task automatic test_busy_reject();
        clear_log();
        offer(1, 8'd8, 128'hA1A2A3A4A5A6A7A8);
        emulate(3, 10);
        offer(1, 8'd9, 128'hB0B0);
        emulate(20, 10);
        n_cmp++; if (err1_cyc.size() != 1 || err1_cyc[0] != 4) begin
            n_bad++; $display("FAIL reject_err1: got %0d pulses, want 1 at cyc 4", err1_cyc.size());
        end
        n_cmp++; if (pkt_cyc.size() != 1 || plen(0) != 8 || pbuf(0) !== 128'hA1A2A3A4A5A6A7A8) begin
            n_bad++; $display("FAIL reject_payload: got %0d pkts len %0d buf %h, want 1 8 a1..a8",
                              pkt_cyc.size(), plen(0), pbuf(0));
        end
        n_cmp++; if (done1_cyc.size() != 1 || d1(0) != 13) begin
            n_bad++; $display("FAIL reject_done: got %0d pulses first %0d, want 1 at 13", done1_cyc.size(), d1(0));
        end
    endtask

    task automatic test_len_bounds();
        clear_log();
        offer(0, 8'd17, 128'hDEAD);
        emulate(6, 3);
        n_cmp++; if (err0_cyc.size() != 1 || err0_cyc[0] != 1) begin
            n_bad++; $display("FAIL len17_err: got %0d pulses, want 1 at cyc 1", err0_cyc.size());
        end
        n_cmp++; if (busy0_seen != 0 || pkt_cyc.size() != 0) begin
            n_bad++; $display("FAIL len17_ignored: got busy %0d pkts %0d, want 0 0", busy0_seen, pkt_cyc.size());
        end
        clear_log();
        offer(0, 8'd16, 128'h0F0E0D0C0B0A09080706050403020100);
        emulate(10, 3);
        n_cmp++; if (plen(0) != 16 || pbuf(0) !== 128'h0F0E0D0C0B0A09080706050403020100 || err0_cyc.size() != 0) begin
            n_bad++; $display("FAIL len16_sent: got len %0d buf %h errs %0d, want 16 0f0e..00 0",
                              plen(0), pbuf(0), err0_cyc.size());
        end
        n_cmp++; if (d0(0) != 6) begin n_bad++; $display("FAIL len16_done: got %0d, want 6", d0(0)); end
        clear_log();
        offer(0, 8'd0, 128'h0);
        emulate(10, 3);
        n_cmp++; if (pkt_cyc.size() != 1 || plen(0) != 0 || err0_cyc.size() != 0 || d0(0) != 6) begin
            n_bad++; $display("FAIL len0_sent: got pkts %0d len %0d errs %0d done %0d, want 1 0 0 6",
                              pkt_cyc.size(), plen(0), err0_cyc.size(), d0(0));
        end
    endtask

    task automatic test_timeout();
        clear_log();
        offer(0, 8'd1, 128'hAA);
        emulate(14, 0);
        n_cmp++; if (pcyc(0) != 2 || done0_cyc.size() != 1 || d0(0) != 11) begin
            n_bad++; $display("FAIL timeout_done: got pkt %0d done %0d x%0d, want 2 11 x1",
                              pcyc(0), d0(0), done0_cyc.size());
        end
        clear_log();
        offer(1, 8'd2, 128'hBB);
        emulate(14, 0);
        n_cmp++; if (pcyc(0) != 2 || d1(0) != 11) begin
            n_bad++; $display("FAIL timeout_idle_again: got pkt %0d done %0d, want 2 11", pcyc(0), d1(0));
        end
    endtask

    task automatic test_reoffer();
        clear_log();
        offer(0, 8'd2, 128'h1122);
        emulate(7, 3);
        offer(0, 8'd4, 128'h33445566);
        emulate(10, 3);
        n_cmp++; if (pcyc(1) != 9 || plen(1) != 4 || err0_cyc.size() != 0) begin
            n_bad++; $display("FAIL reoffer_pkt: got cyc %0d len %0d errs %0d, want 9 4 0",
                              pcyc(1), plen(1), err0_cyc.size());
        end
        n_cmp++; if (done0_cyc.size() != 2 || d0(0) != 6 || d0(1) != 13) begin
            n_bad++; $display("FAIL reoffer_done: got %0d pulses at %0d,%0d, want 2 at 6,13",
                              done0_cyc.size(), d0(0), d0(1));
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        offer(0, 8'd5, 128'h5555);
        emulate(3, 30);
        offer(1, 8'd9, 128'h9999);
        emulate(3, 30);
        n_cmp++; if (req1_busy !== 1'b1 || req0_busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_pending: got busy0=%b busy1=%b, want 1 1", req0_busy, req1_busy);
        end
        rst = 1'b1; tx_busy = 1'b0; busy_left = 0;
        @(negedge clk);
        n_cmp++; if ({tx_packet_wr, req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err} !== 7'b0) begin
            n_bad++; $display("FAIL mid_reset_flags: got %b, want 0000000",
                              {tx_packet_wr, req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err});
        end
        n_cmp++; if (tx_payload_len !== 8'd0 || tx_buf !== 128'd0) begin
            n_bad++; $display("FAIL mid_reset_tx: got len %0d buf %h, want 0 0", tx_payload_len, tx_buf);
        end
        rst = 1'b0;
        clear_log();
        emulate(4, 0);
        n_cmp++; if (done0_cyc.size() + done1_cyc.size() + err0_cyc.size() + err1_cyc.size() + pkt_cyc.size() != 0) begin
            n_bad++; $display("FAIL mid_quiet: got %0d events after reset, want 0",
                              done0_cyc.size() + done1_cyc.size() + err0_cyc.size() + err1_cyc.size() + pkt_cyc.size());
        end
        clear_log();
        offer(0, 8'd3, 128'h333);
        offer(1, 8'd4, 128'h444);
        emulate(20, 5);
        n_cmp++; if (plen(0) != 3 || plen(1) != 4 || pcyc(0) != 2 || pcyc(1) != 9) begin
            n_bad++; $display("FAIL mid_port0_first: got lens %0d,%0d at %0d,%0d, want 3,4 at 2,9",
                              plen(0), plen(1), pcyc(0), pcyc(1));
        end
    endtask

    initial begin
        rst = 1'b0;
        req0_wr = 1'b0; req0_len = '0; req0_buf = '0;
        req1_wr = 1'b0; req1_len = '0; req1_buf = '0;
        tx_busy = 1'b0; busy_left = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_busy_reject();
        test_len_bounds();
        test_timeout();
        test_reoffer();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
